// File: rtl/doa_scan_ctrl.sv
// doa_scan_ctrl: latches one 4-channel IQ snapshot, sweeps the steering ROM over
// a configured angle range and reports the peak-power angle index and its power.
module doa_scan_ctrl #(
    parameter int WORD_LENGTH_IN  = 16,
    parameter int ADDR_WIDTH      = 8,
    parameter int N_ANGLES        = 181,
    parameter int WORD_LENGTH_POW = 80
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [4*WORD_LENGTH_IN-1:0] in_I_x,
    input  logic [4*WORD_LENGTH_IN-1:0] in_Q_x,
    input  logic [ADDR_WIDTH-1:0]       cfg_first,
    input  logic [ADDR_WIDTH-1:0]       cfg_last,
    output logic [4*WORD_LENGTH_IN-1:0] pu_I_x,
    output logic [4*WORD_LENGTH_IN-1:0] pu_Q_x,
    output logic [ADDR_WIDTH-1:0]       rom_addr,
    input  logic [WORD_LENGTH_POW-1:0]  pu_power,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ADDR_WIDTH-1:0]       out_idx,
    output logic [WORD_LENGTH_POW-1:0]  out_power,
    output logic                        out_err
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                      state_q;
    logic [ADDR_WIDTH-1:0]       last_q, rom_addr_q, tag_q, idx_q;
    logic [WORD_LENGTH_POW-1:0]  max_q;
    logic [4*WORD_LENGTH_IN-1:0] pu_I_q, pu_Q_q;
    logic                        issue_q, tag_v_q, cmp_first_q, err_pend_q;
    logic                        in_ready_q, busy_q, out_valid_q, out_err_q;
    logic                        cfg_bad, take;

    assign cfg_bad = (cfg_first > cfg_last) || (int'(cfg_last) >= N_ANGLES);
    assign take    = cmp_first_q || (pu_power > max_q);

    // A bad config still spends one cycle in SCAN so its result shares the n+1 latency shape with n=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= '0;
            rom_addr_q  <= '0;
            tag_q       <= '0;
            idx_q       <= '0;
            max_q       <= '0;
            pu_I_q      <= '0;
            pu_Q_q      <= '0;
            issue_q     <= 1'b0;
            tag_v_q     <= 1'b0;
            cmp_first_q <= 1'b0;
            err_pend_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            tag_q   <= rom_addr_q;
            tag_v_q <= issue_q;
            case (state_q)
                IDLE: if (in_valid) begin
                    pu_I_q      <= in_I_x;
                    pu_Q_q      <= in_Q_x;
                    last_q      <= cfg_last;
                    max_q       <= '0;
                    idx_q       <= cfg_first;
                    cmp_first_q <= 1'b1;
                    err_pend_q  <= cfg_bad;
                    issue_q     <= !cfg_bad;
                    if (!cfg_bad) rom_addr_q <= cfg_first;
                    in_ready_q  <= 1'b0;
                    busy_q      <= 1'b1;
                    state_q     <= SCAN;
                end
                SCAN: begin
                    if (issue_q) begin
                        if (rom_addr_q == last_q) issue_q <= 1'b0;
                        else rom_addr_q <= rom_addr_q + ADDR_WIDTH'(1);
                    end
                    if (err_pend_q) begin
                        out_valid_q <= 1'b1;
                        out_err_q   <= 1'b1;
                        state_q     <= DONE;
                    end else if (tag_v_q) begin
                        if (take) begin
                            max_q <= pu_power;
                            idx_q <= tag_q;
                        end
                        cmp_first_q <= 1'b0;
                        if (tag_q == last_q) begin
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    out_err_q   <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;
    assign out_idx   = idx_q;
    assign out_power = max_q;
    assign rom_addr  = rom_addr_q;
    assign pu_I_x    = pu_I_q;
    assign pu_Q_x    = pu_Q_q;
endmodule

// File: tb/tb_doa_scan_ctrl.sv
// tb_doa_scan_ctrl: directed scoreboard bench with a registered-ROM power model.
module tb_doa_scan_ctrl;
    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_ready, out_ready = 1;
    logic [63:0] in_I_x = '0, in_Q_x = '0, pu_I_x, pu_Q_x;
    logic [7:0]  cfg_first = '0, cfg_last = '0, rom_addr, out_idx, rom_q = '0;
    logic [79:0] pu_power, out_power;
    logic        busy, out_valid, out_err;
    logic [79:0] pow_tab [0:255];
    int          cyc = 0, n_vec = 0, n_err = 0;

    typedef struct {
        logic [7:0]  idx;
        logic [79:0] pw;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sbq[$];

    doa_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_I_x(in_I_x), .in_Q_x(in_Q_x), .cfg_first(cfg_first), .cfg_last(cfg_last),
        .pu_I_x(pu_I_x), .pu_Q_x(pu_Q_x), .rom_addr(rom_addr), .pu_power(pu_power),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_power(out_power), .out_err(out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rom_q <= rom_addr;
    assign pu_power = pow_tab[rom_q];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fill(input logic [79:0] v);
        for (int i = 0; i < 256; i++) pow_tab[i] = v;
    endtask

    task automatic send(input logic [63:0] ix, input logic [63:0] qx, input logic [7:0] f,
                        input logic [7:0] l, input logic [7:0] eidx, input logic [79:0] epw,
                        input logic eerr, input int lat, input bit push);
        exp_t e;
        int t;
        @(negedge clk);
        in_valid = 1; in_I_x = ix; in_Q_x = qx; cfg_first = f; cfg_last = l;
        t = 0;
        while (!in_ready && t < 500) begin @(negedge clk); t++; end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: in_ready stuck at 0");
            in_valid = 0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 0;
        if (push) begin
            e = '{eidx, epw, eerr, lat, cyc};
            sbq.push_back(e);
        end
        chk("pu_I_x_latched", pu_I_x, ix);
        chk("pu_Q_x_latched", pu_Q_x, qx);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while ((!in_ready || sbq.size() != 0) && t < 400) begin @(negedge clk); t++; end
        if (!in_ready || sbq.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL result_timeout: in_ready=%0d pending=%0d", in_ready, sbq.size());
            sbq.delete();
        end
    endtask

    initial begin : monitor
        bit   pv;
        exp_t e;
        pv = 0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && !pv) begin
                if (sbq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_result: idx=%0d err=%0d, no result expected", out_idx, out_err);
                end else begin
                    e = sbq.pop_front();
                    chk("out_idx", out_idx, e.idx);
                    chk("out_power", out_power, e.pw);
                    chk("out_err", out_err, e.err);
                    chk("latency", 80'(cyc - e.acc), 80'(e.lat));
                end
            end
            pv = rst_n && out_valid;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_err"}, out_err, 1'b0);
        chk({tag, "_out_idx"}, out_idx, 8'd0);
        chk({tag, "_out_power"}, out_power, 80'd0);
        chk({tag, "_rom_addr"}, rom_addr, 8'd0);
        chk({tag, "_pu_I_x"}, pu_I_x, 64'd0);
        chk({tag, "_pu_Q_x"}, pu_Q_x, 64'd0);
    endtask

    initial begin : stim
        logic [63:0] a_i, b_i;
        fill(80'd0);
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1;

        fill(80'd100); pow_tab[14] = 80'd1000; pow_tab[9] = 80'd5000; pow_tab[20] = 80'd5000;
        send(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 8'd10, 8'd19, 8'd14, 80'd1000, 1'b0, 11, 1);
        chk("busy_scan", busy, 1'b1);
        wait_idle();

        fill(80'd10); pow_tab[3] = 80'd500; pow_tab[7] = 80'd500;
        send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 8'd0, 8'd9, 8'd3, 80'd500, 1'b0, 11, 1);
        wait_idle();

        fill(80'd0); pow_tab[42] = 80'd7; pow_tab[41] = 80'd900; pow_tab[43] = 80'd900;
        send(64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A, 8'd42, 8'd42, 8'd42, 80'd7, 1'b0, 2, 1);
        wait_idle();

        fill(80'd77);
        send(64'h1, 64'h2, 8'd20, 8'd5, 8'd20, 80'd0, 1'b1, 1, 1);
        wait_idle();
        send(64'h3, 64'h4, 8'd3, 8'd181, 8'd3, 80'd0, 1'b1, 1, 1);
        wait_idle();
        chk("err_cleared", out_err, 1'b0);

        a_i = 64'hCAFE_BABE_DEAD_BEEF;
        b_i = 64'h0F0F_0F0F_0F0F_0F0F;
        fill(80'd5); pow_tab[2] = 80'd9;
        out_ready = 0;
        send(a_i, 64'h0, 8'd0, 8'd4, 8'd2, 80'd9, 1'b0, 6, 1);
        begin
            int t = 0;
            while (!out_valid && t < 50) begin @(negedge clk); t++; end
            if (!out_valid) begin n_vec++; n_err++; $display("FAIL bp_valid_timeout: out_valid=0"); end
        end
        in_valid = 1; in_I_x = b_i; in_Q_x = 64'h1; cfg_first = 8'd30; cfg_last = 8'd30;
        repeat (20) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_out_idx", out_idx, 8'd2);
            chk("bp_out_power", out_power, 80'd9);
            chk("bp_pu_I_x", pu_I_x, a_i);
        end
        out_ready = 1;
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1'b1);
        chk("bp_release_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        in_valid = 0;
        sbq.push_back('{8'd30, 80'd5, 1'b0, 2, cyc});
        chk("bp_next_accept_busy", busy, 1'b1);
        chk("bp_next_pu_I_x", pu_I_x, b_i);
        wait_idle();

        for (int i = 0; i < 181; i++) pow_tab[i] = {1'b1, 19'((i * 97) % 181), 28'hABCDEF0, 32'(i)};
        send({4{16'h7FFF}}, {4{16'h8000}}, 8'd0, 8'd180, 8'd153,
             {1'b1, 19'd180, 28'hABCDEF0, 32'd153}, 1'b0, 182, 1);
        wait_idle();

        send(64'h7777, 64'h8888, 8'd0, 8'd180, 8'd0, 80'd0, 1'b0, 0, 0);
        repeat (50) @(negedge clk);
        #2 rst_n = 0;
        #1 chk_reset_vals("midscan_rst");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);
        repeat (200) @(negedge clk);
        chk("post_rst_no_valid", out_valid, 1'b0);
        chk("scoreboard_empty", 80'(sbq.size()), 80'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/doa_scan_ctrl.md
Name: doa_scan_ctrl

Overview:
Sequencer for the 4-channel steering-vector power unit in the ULA DOA datapath. It accepts one 4-channel IQ snapshot and holds it on the power unit's sample inputs. It then sweeps a steering-vector ROM over a configured angle range, registers the power returned for each angle and tracks the running maximum. It reports the argmax angle index and its power through a valid/ready result interface.

Parameters:
WORD_LENGTH_IN, 16, width of each I/Q sample lane
ADDR_WIDTH, 8, steering ROM address / angle index width
N_ANGLES, 181, number of ROM entries; valid indices are 0..N_ANGLES-1
WORD_LENGTH_POW, 80, power word width ((2*WORD_LENGTH_IN+8)*2)

Ports:
clk  in  1  system clock; the only clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  snapshot valid
in_ready  out  1  snapshot accepted when in_valid & in_ready
in_I_x  in  4*WORD_LENGTH_IN  packed I lanes; ch1 in the LSBs
in_Q_x  in  4*WORD_LENGTH_IN  packed Q lanes; ch1 in the LSBs
cfg_first  in  ADDR_WIDTH  first angle index; sampled at accept
cfg_last  in  ADDR_WIDTH  last angle index, inclusive; sampled at accept
pu_I_x  out  4*WORD_LENGTH_IN  latched I lanes to the power unit
pu_Q_x  out  4*WORD_LENGTH_IN  latched Q lanes to the power unit
rom_addr  out  ADDR_WIDTH  steering ROM address; ROM has 1-cycle registered read
pu_power  in  WORD_LENGTH_POW  combinational power for the current ROM word; unsigned
busy  out  1  high in SCAN and DONE
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid & out_ready
out_idx  out  ADDR_WIDTH  argmax angle index
out_power  out  WORD_LENGTH_POW  maximum power
out_err  out  1  configuration error flag for this result

Behaviour:
- Reset (async, rst_n=0): state IDLE. in_ready=1. busy=0, out_valid=0, out_err=0. out_idx=0, out_power=0, rom_addr=0, pu_I_x=0, pu_Q_x=0. All pipeline tags cleared.
- Reset deasserted mid-scan or mid-DONE: scan is discarded; no result is produced.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On accept: latch in_I_x/in_Q_x into pu_I_x/pu_Q_x, latch cfg_first/cfg_last, clear the max register and the first-compare flag.
  - If cfg_first > cfg_last or cfg_last >= N_ANGLES: go to DONE with out_err=1, out_idx=cfg_first, out_power=0.
  - Otherwise: rom_addr=cfg_first and go to SCAN.
- SCAN:
  - in_ready=0; in_valid is ignored.
  - Each cycle rom_addr increments by 1 until it reaches cfg_last, then holds.
  - An address tag (index plus valid bit) is delayed one cycle to align with the ROM output.
  - When the tag is valid, pu_power is compared at the clock edge. Update the max if this is the first compare or pu_power > max (strict).
  - Ties keep the lower index.
  - The compare for tag==cfg_last moves the state to DONE in the same edge.
- Latency: with n = cfg_last - cfg_first + 1, out_valid rises n+1 cycles after the accept edge. For n=1 that is 2 cycles. Error results rise 1 cycle after accept.
- DONE:
  - out_valid=1; out_idx, out_power and out_err are held stable while out_ready=0.
  - On out_ready: out_valid=0, out_err=0, go to IDLE. in_ready goes high the following cycle; there is no same-cycle accept.
- pu_I_x/pu_Q_x are held constant from accept until the next accept.
- rom_addr never exceeds cfg_last. No wrap-around.
- Arithmetic: power comparison is unsigned over the full WORD_LENGTH_POW bits. No truncation.

Test Plan:
- Reset: assert rst_n=0 mid-scan (cfg 0..180) -> all outputs at reset values immediately; after release, in_ready=1 and no out_valid for the aborted scan.
- Basic sweep: cfg_first=10, cfg_last=19; power model returns 100 for every index except 1000 at index 14 -> out_idx=14, out_power=1000, out_err=0; out_valid exactly 11 cycles after accept.
- Tie and single angle: powers 500 at indices 3 and 7, cfg 0..9 -> out_idx=3. Separately, cfg 42..42 -> out_idx=42, out_valid 2 cycles after accept.
- Config error: cfg_first=20, cfg_last=5 -> out_err=1, out_idx=20, out_power=0, 1 cycle after accept. Then cfg_last=181 -> out_err=1.
- Backpressure: hold out_ready=0 for 20 cycles while driving in_valid=1 with new data -> in_ready stays 0, result stable, pu_I_x unchanged. Release -> next snapshot accepted one cycle later.
- Full range: max-magnitude snapshot (all lanes 16'h7FFF / 16'h8000) over cfg 0..180 -> index matches the golden model, 182-cycle latency, full 80-bit power comparison correct.
